// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*)
// and downstream (out_*) sides. The stage itself uses the slave view;
// the surrounding pipeline uses the master view.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
// out_* is driven only from the main register; the skid entry refills the
// main register when the downstream takes the current beat.
module pipe_stage_reg #(
  parameter int DATA_W     = 128,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int STALL_W    = 16
) (
  input  logic               clock,
  input  logic               reset_0,
  pipe_stage_reg_if.slave    bus,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cycles
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [STALL_W-1:0] r_stall;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  // in_ready: registered (skid empty) with SKID, else combinational pass-through
  always_comb begin
    if (SKID != 0) w_in_ready = !r_skid_valid;
    else           w_in_ready = !r_main_valid | bus.out_ready;
  end

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_main_valid & bus.out_ready;

  // next-state of the valid bits and selection of which payload register loads
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (SKID != 0) begin
      if (!r_main_valid) begin
        if (w_in_fire) begin
          w_load_main_in   = 1'b1;
          w_main_valid_nxt = 1'b1;
        end
      end else if (!r_skid_valid) begin
        if (w_out_fire) begin
          if (w_in_fire) w_load_main_in   = 1'b1;
          else           w_main_valid_nxt = 1'b0;
        end else if (w_in_fire) begin
          w_load_skid      = 1'b1;
          w_skid_valid_nxt = 1'b1;
        end
      end else if (w_out_fire) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else begin
      if (w_in_fire) begin
        w_load_main_in   = 1'b1;
        w_main_valid_nxt = 1'b1;
      end else if (w_out_fire) begin
        w_main_valid_nxt = 1'b0;
      end
    end
    // flush kills everything held, including a beat accepted this cycle
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // valid bit registers
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // payload registers: written on load, zeroed on flush when bubbles must be NOPs
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (flush && (CLEAR_DATA != 0)) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in)        r_main_data <= bus.in_data;
      else if (w_load_main_skid) r_main_data <= r_skid_data;
      if (w_load_skid)           r_skid_data <= bus.in_data;
    end
  end

  // saturating count of cycles where the downstream refuses a valid beat
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      r_stall <= '0;
    end else if (r_main_valid && !bus.out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  assign occupancy     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  assign stall_cycles  = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, pass-through, narrow
// stall counter) with FIFO scoreboards and a stall-count model.
module tb_pipe_stage_reg;

  logic clock;
  logic reset_0;
  logic flush_a, flush_b, flush_c;
  logic [1:0]  occ_a, occ_b, occ_c;
  logic [15:0] stall_a, stall_b;
  logic [3:0]  stall_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] qa[$];
  logic [31:0]  qb[$];
  logic [15:0]  sa, sb;

  pipe_stage_reg_if #(.DATA_W(128)) bus_a ();
  pipe_stage_reg_if #(.DATA_W(32))  bus_b ();
  pipe_stage_reg_if #(.DATA_W(8))   bus_c ();

  pipe_stage_reg #(.DATA_W(128), .SKID(1), .CLEAR_DATA(1), .STALL_W(16)) u_a (
    .clock(clock), .reset_0(reset_0), .bus(bus_a), .flush(flush_a),
    .occupancy(occ_a), .stall_cycles(stall_a));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CLEAR_DATA(1), .STALL_W(16)) u_b (
    .clock(clock), .reset_0(reset_0), .bus(bus_b), .flush(flush_b),
    .occupancy(occ_b), .stall_cycles(stall_b));

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CLEAR_DATA(1), .STALL_W(4)) u_c (
    .clock(clock), .reset_0(reset_0), .bus(bus_c), .flush(flush_c),
    .occupancy(occ_c), .stall_cycles(stall_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // scoreboard for the skid instance: compare state, then advance the model
  always @(negedge clock) begin
    if (!reset_0) begin
      qa.delete();
      sa = 0;
    end else begin
      chk("a_occ",   occ_a, qa.size());
      chk("a_vld",   bus_a.out_valid, qa.size() != 0);
      if (qa.size() != 0) chk("a_data", bus_a.out_data, qa[0]);
      chk("a_rdy",   bus_a.in_ready, qa.size() < 2);
      chk("a_stall", stall_a, sa);
      if (qa.size() != 0 && !bus_a.out_ready && sa != 16'hFFFF) sa = sa + 1;
      begin
        automatic bit m_rdy = (qa.size() < 2);
        if (qa.size() != 0 && bus_a.out_ready) void'(qa.pop_front());
        if (flush_a) qa.delete();
        else if (bus_a.in_valid && m_rdy) qa.push_back(bus_a.in_data);
      end
    end
  end

  // scoreboard for the pass-through instance
  always @(negedge clock) begin
    if (!reset_0) begin
      qb.delete();
      sb = 0;
    end else begin
      chk("b_occ",   occ_b, qb.size());
      chk("b_vld",   bus_b.out_valid, qb.size() != 0);
      if (qb.size() != 0) chk("b_data", bus_b.out_data, qb[0]);
      chk("b_rdy",   bus_b.in_ready, (qb.size() == 0) || bus_b.out_ready);
      chk("b_stall", stall_b, sb);
      if (qb.size() != 0 && !bus_b.out_ready && sb != 16'hFFFF) sb = sb + 1;
      begin
        automatic bit m_rdy = (qb.size() == 0) || bus_b.out_ready;
        if (qb.size() != 0 && bus_b.out_ready) void'(qb.pop_front());
        if (flush_b) qb.delete();
        else if (bus_b.in_valid && m_rdy) qb.push_back(bus_b.in_data);
      end
    end
  end

  initial begin
    reset_0 = 1'b0;
    flush_a = 0; flush_b = 0; flush_c = 0;
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0;
    bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.out_ready = 0;
    bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.out_ready = 0;
    #2;
    chk("rst_vld",  bus_a.out_valid, 0);
    chk("rst_data", bus_a.out_data, 0);
    chk("rst_occ",  occ_a, 0);
    chk("rst_rdy",  bus_a.in_ready, 1);
    chk("rst_stall", stall_a, 0);
    #21 reset_0 = 1'b1;
    step();

    // streaming 1..4 at full rate
    bus_a.out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_data  = 128'(i);
      step();
      chk("stream_data", bus_a.out_data, 128'(i));
      chk("stream_occ",  occ_a, 1);
    end
    bus_a.in_valid = 0;
    step();
    chk("stream_stall", stall_a, 0);

    // back-pressure: A then B while stalled
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = 128'hA; step();
    bus_a.in_data = 128'hB; step();
    bus_a.in_valid = 0;
    chk("bp_occ",  occ_a, 2);
    chk("bp_rdy",  bus_a.in_ready, 0);
    chk("bp_head", bus_a.out_data, 128'hA);
    step(); step();
    chk("bp_stall", stall_a, 3);
    bus_a.out_ready = 1;
    step();
    chk("bp_second", bus_a.out_data, 128'hB);
    chk("bp_rdy_back", bus_a.in_ready, 1);
    step();
    chk("bp_empty", occ_a, 0);

    // flush with skid full; upstream presents C
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = 128'hA; step();
    bus_a.in_data = 128'hB; step();
    bus_a.in_data = 128'hC; flush_a = 1;
    step();
    flush_a = 0; bus_a.in_valid = 0;
    chk("fl_vld",  bus_a.out_valid, 0);
    chk("fl_occ",  occ_a, 0);
    chk("fl_data", bus_a.out_data, 0);
    chk("fl_rdy",  bus_a.in_ready, 1);
    // flush while a beat is actually accepted: it must vanish
    bus_a.in_valid = 1; bus_a.in_data = 128'hD; step();
    bus_a.in_data = 128'hC; flush_a = 1; step();
    flush_a = 0; bus_a.in_valid = 0;
    chk("fl2_occ", occ_a, 0);
    bus_a.out_ready = 1;
    bus_a.in_valid = 1; bus_a.in_data = 128'hE; step();
    bus_a.in_valid = 0;
    chk("fl2_next", bus_a.out_data, 128'hE);
    step();

    // pass-through instance: combinational in_ready
    bus_b.out_ready = 0;
    bus_b.in_valid = 1; bus_b.in_data = 32'h5; step();
    bus_b.in_data = 32'h6;
    #1 chk("b_rdy_block", bus_b.in_ready, 0);
    bus_b.out_ready = 1;
    #1 chk("b_rdy_comb", bus_b.in_ready, 1);
    step();
    chk("b_next", bus_b.out_data, 32'h6);
    chk("b_vld_next", bus_b.out_valid, 1);
    bus_b.in_valid = 1; bus_b.in_data = 32'h7; step();
    bus_b.in_valid = 0; step();
    chk("b_empty", occ_b, 0);

    // narrow stall counter saturates at 15
    bus_c.in_valid = 1; bus_c.in_data = 8'h9; step();
    bus_c.in_valid = 0;
    repeat (14) step();
    chk("sat_14", stall_c, 14);
    repeat (6) step();
    chk("sat_15", stall_c, 15);
    chk("sat_data", bus_c.out_data, 8'h9);

    // random traffic with occasional flush on the skid instance
    for (int i = 0; i < 400; i++) begin
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.out_ready = 1'($urandom_range(0, 1));
      bus_a.in_data   = {$urandom, $urandom, $urandom, $urandom};
      flush_a         = ($urandom_range(0, 15) == 0);
      step();
    end
    flush_a = 0; bus_a.in_valid = 0; bus_a.out_ready = 1;
    repeat (3) step();

    // async reset mid-cycle with two entries held
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = 128'h11; step();
    bus_a.in_data = 128'h22; step();
    bus_a.in_valid = 0;
    chk("ar_pre_occ", occ_a, 2);
    #2 reset_0 = 1'b0;
    #1;
    chk("ar_vld",   bus_a.out_valid, 0);
    chk("ar_data",  bus_a.out_data, 0);
    chk("ar_occ",   occ_a, 0);
    chk("ar_rdy",   bus_a.in_ready, 1);
    chk("ar_stall", stall_a, 0);
    @(posedge clock);
    #3 reset_0 = 1'b1;
    bus_a.out_ready = 1;
    bus_a.in_valid = 1; bus_a.in_data = 128'h7;
    step();
    bus_a.in_valid = 0;
    chk("ar_beat",     bus_a.out_data, 128'h7);
    chk("ar_beat_vld", bus_a.out_valid, 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed per-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit payload (packed datapath plus control bits) with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
- A stall in a later stage no longer needs a global enable; back-pressure propagates by handshake.
- Includes a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 128, payload width in bits (≥1).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_DATA, 1, 1 = flush zeroes payload registers (bubble = all-zero control = NOP); 0 = flush clears valid bits only.
- STALL_W, 16, width of stall counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_0  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage accepts payload this cycle.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  synchronous kill of all held entries (branch mispredict/exception).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload to next stage.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).
- stall_cycles  output  STALL_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (reset_0=0, async, immediate): main/skid valid=0, main/skid data=0, stall_cycles=0. Result: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid/out_data are driven from the main register only; no combinational path from in_* to out_*.
- SKID=1:
  - in_ready = !skid_valid (registered, no dependency on out_ready).
  - main empty: in_fire → main=in_data, valid next cycle (1-cycle latency).
  - main full, skid empty, out_fire: main=in_data if in_fire, else main becomes empty.
  - main full, skid empty, no out_fire: in_fire → skid=in_data; in_ready=0 from next cycle.
  - main full, skid full: no input possible. out_fire → main=skid, skid empty, in_ready=1 next cycle.
  - Order is strictly FIFO; skid is never valid while main is empty.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main; out_fire without in_fire empties main. Back-to-back throughput is 1/cycle.
- Flush:
  - flush=1 at a clock edge clears both valid bits regardless of in_fire/out_fire. A payload accepted in that cycle is discarded.
  - If CLEAR_DATA=1, both data registers are zeroed.
  - in_ready is unaffected in the flush cycle (an upstream beat handshakes and is dropped); it is 1 afterwards.
- Payload registers are written only on the load conditions above. They hold their value otherwise; with CLEAR_DATA=1 they are also zeroed on flush.
- occupancy = main_valid + skid_valid.
- Stall counter:
  - stall_cycles increments by 1 on each edge where out_valid & !out_ready.
  - Saturates at 2^STALL_W−1 (no wrap).
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-transfer overrides everything; state is lost, and the first post-reset cycle behaves as empty.

Test Plan:
- Streaming, SKID=1: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later, out_valid continuous, occupancy=1, stall_cycles=0.
- Back-pressure, SKID=1: send 0xA then 0xB while out_ready=0 → occupancy=2 and in_ready=0 on the cycle after 0xB is accepted, out_data=0xA held, stall_cycles increments each stalled cycle. Raise out_ready → 0xA then 0xB emitted, in_ready returns to 1.
- Flush with skid full (0xA, 0xB) and a simultaneous in_fire of 0xC → next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_DATA=1), 0xC never appears, stall_cycles unchanged.
- SKID=0 pass-through: out_ready=0 holding 0x5, in_valid=1 → in_ready=0. Set out_ready=1 in the same cycle → in_ready=1 combinationally, next out_data is the new beat.
- Saturation: STALL_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cycles stops at 15.
- Async reset: assert reset_0 mid-cycle with occupancy=2 → outputs go to 0 immediately (before the next clock edge), in_ready=1. After release, a fresh beat 0x7 appears at out_data one cycle after acceptance.
